// File: rtl/return_stack.sv
// return_stack: LIFO return-address stack (push PC on CALL, pop on RET), falling-edge state.
// Latency: pushed/popped results visible on outputs one falling edge later; outputs are registered state only.
// Backpressure: none; full push sets sticky overflow (dropped, or overwrites oldest with RETURN_STACK_WRAP_EN).
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       inClk,
  input  logic                       inClr,
  input  logic                       inPush,
  input  logic                       inPop,
  input  logic [WIDTH-1:0]           inData,
  output logic [WIDTH-1:0]           outData,
  output logic [$clog2(DEPTH+1)-1:0] outCount,
  output logic                       outEmpty,
  output logic                       outFull,
  output logic                       outOverflow,
  output logic                       outUnderflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Storage is addressed by a physical write pointer that wraps modulo DEPTH.
  // Without wrap it simply tracks sp; with wrap it lets a full push land on
  // the oldest slot while sp saturates at DEPTH.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_sp;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_wr_nxt;
  logic [CW-1:0]    w_sp_nxt;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == CW'(DEPTH));
  assign w_top_idx = r_wr - AW'(1);

  // Decode the requested operation against current occupancy, in priority order.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_wr;
    w_wr_nxt  = r_wr;
    w_sp_nxt  = r_sp;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (inPush && inPop && !w_empty) begin
      // Replace top in place; depth and flags untouched.
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (inPush) begin
      // Covers push+pop on empty, which behaves as a plain push.
      if (!w_full) begin
        w_wr_en  = 1'b1;
        w_wr_nxt = r_wr + AW'(1);
        w_sp_nxt = r_sp + CW'(1);
      end else begin
        w_ovf_set = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
        // r_wr points at the oldest entry when full; overwrite it and advance.
        w_wr_en  = 1'b1;
        w_wr_nxt = r_wr + AW'(1);
`endif
      end
    end else if (inPop) begin
      if (!w_empty) begin
        w_wr_nxt = r_wr - AW'(1);
        w_sp_nxt = r_sp - CW'(1);
      end else begin
        w_unf_set = 1'b1;
      end
    end
  end

  // Pointer and sticky-flag state; clear aborts any operation on the same edge.
  always_ff @(negedge inClk) begin
    if (inClr) begin
      r_wr  <= '0;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_wr  <= w_wr_nxt;
      r_sp  <= w_sp_nxt;
      r_ovf <= r_ovf | w_ovf_set;
      r_unf <= r_unf | w_unf_set;
    end
  end

  // Storage words; contents are left as-is on clear since an empty stack reads 0.
  always_ff @(negedge inClk) begin
    if (!inClr && w_wr_en) begin
      r_mem[w_wr_idx] <= inData;
    end
  end

  assign outData      = w_empty ? '0 : r_mem[w_top_idx];
  assign outCount     = r_sp;
  assign outEmpty     = w_empty;
  assign outFull      = w_full;
  assign outOverflow  = r_ovf;
  assign outUnderflow = r_unf;

endmodule

// File: tb/tb_return_stack.sv
// Testbench for return_stack: directed test-plan scenarios plus randomized ops vs a queue model.
// Inputs change after the rising edge; DUT updates on the falling edge; outputs sampled 1 time unit later.
// Model honours RETURN_STACK_WRAP_EN the same way the build does.
module tb_return_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             clr, push, pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    cnt;
  logic             empty, full, ovf, unf;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] m_q[$];
  logic             m_ovf, m_unf;

  always #5 clk = ~clk;

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .inClk(clk), .inClr(clr), .inPush(push), .inPop(pop), .inData(din),
    .outData(dout), .outCount(cnt), .outEmpty(empty), .outFull(full),
    .outOverflow(ovf), .outUnderflow(unf)
  );

  task automatic model_apply(input logic c, input logic pu, input logic po, input logic [WIDTH-1:0] d);
    if (c) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (pu && po && m_q.size() > 0) begin
      m_q[m_q.size()-1] = d;
    end else if (pu) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(d);
      end else begin
        m_ovf = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
        void'(m_q.pop_front());
        m_q.push_back(d);
`endif
      end
    end else if (po) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  // One cycle: drive after rising edge, DUT acts on falling edge, settle 1 unit.
  task automatic step(input logic c, input logic pu, input logic po, input logic [WIDTH-1:0] d);
    @(posedge clk);
    clr = c; push = pu; pop = po; din = d;
    @(negedge clk);
    model_apply(c, pu, po, d);
    #1;
    clr = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    checks++; if (cnt !== 4'd0)  begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0)  begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", dout); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", ovf, unf); end
  endtask

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 16'h0010 + 16'(i));
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] exp;
    step(1'b1, 1'b0, 1'b0, '0);
    fill();
    checks++; if (full !== 1'b1 || cnt !== 4'd8) begin errors++; $display("FAIL fill_full got full=%b cnt=%0d exp 1 8", full, cnt); end
    checks++; if (dout !== 16'h0017) begin errors++; $display("FAIL fill_top got %h exp 0017", dout); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      exp = (i < DEPTH-1) ? 16'h0016 - 16'(i) : 16'h0000;
      checks++; if (dout !== exp) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, dout, exp); end
    end
    checks++; if (empty !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin
      errors++; $display("FAIL drain_end got empty=%b ovf=%b unf=%b exp 1 0 0", empty, ovf, unf); end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp;
    step(1'b1, 1'b0, 1'b0, '0);
    fill();
    step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", cnt); end
`ifdef RETURN_STACK_WRAP_EN
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i == 0) ? 16'hBEEF : 16'h0018 - 16'(i);
      checks++; if (dout !== exp) begin errors++; $display("FAIL wrap_pop[%0d] got %h exp %h", i, dout, exp); end
      step(1'b0, 1'b0, 1'b1, '0);
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      exp = 16'h0017 - 16'(i);
      checks++; if (dout !== exp) begin errors++; $display("FAIL drop_pop[%0d] got %h exp %h", i, dout, exp); end
      step(1'b0, 1'b0, 1'b1, '0);
    end
`endif
    checks++; if (empty !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_end got empty=%b ovf=%b exp 1 1", empty, ovf); end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    checks++; if (unf !== 1'b1 || cnt !== 4'd0) begin errors++; $display("FAIL unf_pop got unf=%b cnt=%0d exp 1 0", unf, cnt); end
    step(1'b0, 1'b1, 1'b0, 16'hA5A5);
    checks++; if (dout !== 16'hA5A5) begin errors++; $display("FAIL unf_push_data got %h exp a5a5", dout); end
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b exp 1", unf); end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", unf); end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 16'h0001);
    step(1'b0, 1'b1, 1'b0, 16'h0002);
    step(1'b0, 1'b1, 1'b1, 16'h0099);
    checks++; if (cnt !== 4'd2 || dout !== 16'h0099) begin errors++; $display("FAIL pp_replace got cnt=%0d data=%h exp 2 0099", cnt, dout); end
    step(1'b0, 1'b0, 1'b1, '0);
    checks++; if (dout !== 16'h0001) begin errors++; $display("FAIL pp_below got %h exp 0001", dout); end
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 16'h0042);
    checks++; if (cnt !== 4'd1 || dout !== 16'h0042 || unf !== 1'b0) begin
      errors++; $display("FAIL pp_empty got cnt=%0d data=%h unf=%b exp 1 0042 0", cnt, dout, unf); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_d;
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, WIDTH'($urandom));
      exp_d = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
      checks++;
      if (dout !== exp_d || cnt !== CW'(m_q.size()) || empty !== (m_q.size() == 0) ||
          full !== (m_q.size() == DEPTH) || ovf !== m_ovf || unf !== m_unf) begin
        errors++;
        $display("FAIL rand[%0d] got data=%h cnt=%0d e=%b f=%b o=%b u=%b exp data=%h cnt=%0d o=%b u=%b",
                 i, dout, cnt, empty, full, ovf, unf, exp_d, m_q.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
